// File: rtl/batcharger_ctrl.sv
// ---------------------------------------------------------------------------
// BatchargerCtrl: battery charger mode controller.
//
// Sequences a battery through trickle (TC), constant-current (CC) and
// constant-voltage (CV) charging, parks it in END when the charge is done and
// restarts CC when the battery voltage sags (recharge). Every transition out
// of TC, CC, CV and END must see its exit condition hold for DEB consecutive
// cycles; CV can also end on a prescaled timeout.
//
// Ports
//   clk                  single clock, all state updates on the rising edge
//   rst                  asynchronous active-high reset
//   en, vtok             charger enable and supply/temperature OK; either low
//                        forces IDLE from any state
//   vbat, ibat           battery voltage and current codes
//   vcutoff              trickle-to-CC voltage threshold
//   vpreset              recharge voltage threshold
//   vcv_cfg, icc_cfg,
//   itc_cfg, iend_cfg    CV target, CC current, TC current, CV end current
//   tmax                 CV timeout in timer ticks, 0 disables it
//   cc, tc, cv           registered mode enables to the power stage
//   vcv, icc, itc        targets latched on every exit from IDLE
//   state                IDLE=0, TC=1, CC=2, CV=3, END=4
// ---------------------------------------------------------------------------
module batcharger_ctrl #(
  parameter int DEB    = 4,
  parameter int TPRESC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vtok,
  input  logic [7:0] vbat,
  input  logic [7:0] ibat,
  input  logic [7:0] vcutoff,
  input  logic [7:0] vpreset,
  input  logic [7:0] vcv_cfg,
  input  logic [7:0] icc_cfg,
  input  logic [7:0] itc_cfg,
  input  logic [7:0] iend_cfg,
  input  logic [7:0] tmax,
  output logic       cc,
  output logic       tc,
  output logic       cv,
  output logic [7:0] vcv,
  output logic [7:0] icc,
  output logic [7:0] itc,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TC   = 3'd1,
    CC   = 3'd2,
    CV   = 3'd3,
    END  = 3'd4
  } stateT;

  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int PW = (TPRESC > 1) ? $clog2(TPRESC) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TPRESC - 1);

  stateT         state_q, state_d;
  logic          cc_q, cc_d;
  logic          tc_q, tc_d;
  logic          cv_q, cv_d;
  logic [7:0]    vcv_q, vcv_d;
  logic [7:0]    icc_q, icc_d;
  logic [7:0]    itc_q, itc_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tick_q, tick_d;

  logic exitCond;
  logic debDone;
  logic timeout;

  // All state lives here; mode enables are registered alongside the state so
  // they change on the same edge, and the async reset clears everything
  // (including the mode enables) without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cc_q    <= 1'b0;
      tc_q    <= 1'b0;
      cv_q    <= 1'b0;
      vcv_q   <= 8'd0;
      icc_q   <= 8'd0;
      itc_q   <= 8'd0;
      deb_q   <= '0;
      presc_q <= '0;
      tick_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      tc_q    <= tc_d;
      cv_q    <= cv_d;
      vcv_q   <= vcv_d;
      icc_q   <= icc_d;
      itc_q   <= itc_d;
      deb_q   <= deb_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic: CV timer, per-state exit condition, shared debounce
  // counter, target latching and the registered mode enables.
  always_comb begin
    state_d  = state_q;
    vcv_d    = vcv_q;
    icc_d    = icc_q;
    itc_d    = itc_q;
    deb_d    = deb_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    exitCond = 1'b0;

    // The timer only advances while in CV; the tick count saturates at 255.
    if (state_q == CV) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (tick_q != 8'hFF) begin
          tick_d = tick_q + 8'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Timeout is judged on the updated tick count so END is reached on the
    // very edge that completes the tmax-th tick.
    timeout = (state_q == CV) && (tmax != 8'd0) && (tick_d == tmax);

    unique case (state_q)
      TC:      exitCond = (vbat >= vcutoff);
      CC:      exitCond = (vbat >= vcv_q);
      CV:      exitCond = (ibat < iend_cfg);
      END:     exitCond = (vbat < vpreset);
      default: exitCond = 1'b0;
    endcase

    // The DEB-th consecutive true cycle is the one where the counter already
    // holds DEB-1 and the condition is still true.
    debDone = exitCond && (deb_q == DEB_LAST);

    unique case (state_q)
      IDLE: begin
        if (vbat < vcutoff) begin
          state_d = TC;
        end else if (vbat < vcv_cfg) begin
          state_d = CC;
        end else begin
          state_d = CV;
        end
      end
      TC:      if (debDone) state_d = CC;
      CC:      if (debDone) state_d = CV;
      CV:      if (debDone || timeout) state_d = END;
      END:     if (debDone) state_d = CC;
      default: state_d = IDLE;
    endcase

    if (!en || !vtok) begin
      state_d = IDLE;
    end

    // Any state change or any false cycle restarts the debounce count.
    if ((state_d != state_q) || !exitCond) begin
      deb_d = '0;
    end else begin
      deb_d = deb_q + 1'b1;
    end

    if ((state_d == CV) && (state_q != CV)) begin
      presc_d = '0;
      tick_d  = 8'd0;
    end

    // Targets are captured only when leaving IDLE, so config changes during
    // a charge cycle do not disturb the power stage.
    if ((state_q == IDLE) && (state_d != IDLE)) begin
      vcv_d = vcv_cfg;
      icc_d = icc_cfg;
      itc_d = itc_cfg;
    end

    tc_d = (state_d == TC);
    cc_d = (state_d == CC);
    cv_d = (state_d == CV);
  end

  assign state = state_q;
  assign cc    = cc_q;
  assign tc    = tc_q;
  assign cv    = cv_q;
  assign vcv   = vcv_q;
  assign icc   = icc_q;
  assign itc   = itc_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// ---------------------------------------------------------------------------
// TbBatchargerCtrl: directed self-checking bench for batcharger_ctrl with
// DEB=4 and TPRESC=16. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_batcharger_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       vtok;
  logic [7:0] vbat;
  logic [7:0] ibat;
  logic [7:0] vcutoff;
  logic [7:0] vpreset;
  logic [7:0] vcv_cfg;
  logic [7:0] icc_cfg;
  logic [7:0] itc_cfg;
  logic [7:0] iend_cfg;
  logic [7:0] tmax;
  logic       cc;
  logic       tc;
  logic       cv;
  logic [7:0] vcv;
  logic [7:0] icc;
  logic [7:0] itc;
  logic [2:0] state;

  int testsRun = 0;
  int testsFailed = 0;

  batcharger_ctrl #(.DEB(4), .TPRESC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .vtok     (vtok),
    .vbat     (vbat),
    .ibat     (ibat),
    .vcutoff  (vcutoff),
    .vpreset  (vpreset),
    .vcv_cfg  (vcv_cfg),
    .icc_cfg  (icc_cfg),
    .itc_cfg  (itc_cfg),
    .iend_cfg (iend_cfg),
    .tmax     (tmax),
    .cc       (cc),
    .tc       (tc),
    .cv       (cv),
    .vcv      (vcv),
    .icc      (icc),
    .itc      (itc),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkModes(input string tag, input logic [2:0] expState,
                            input logic expTc, input logic expCc, input logic expCv);
    checkOutput({tag, ".state"}, {5'd0, state}, {5'd0, expState});
    checkOutput({tag, ".tc"}, {7'd0, tc}, {7'd0, expTc});
    checkOutput({tag, ".cc"}, {7'd0, cc}, {7'd0, expCc});
    checkOutput({tag, ".cv"}, {7'd0, cv}, {7'd0, expCv});
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    vtok     = 1'b0;
    vbat     = 8'd0;
    ibat     = 8'd0;
    vcutoff  = 8'd0;
    vpreset  = 8'd0;
    vcv_cfg  = 8'd0;
    icc_cfg  = 8'd0;
    itc_cfg  = 8'd0;
    iend_cfg = 8'd0;
    tmax     = 8'd0;

    // Reset values while rst is held
    #3;
    checkModes("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.vcv", vcv, 8'd0);
    checkOutput("reset.icc", icc, 8'd0);
    checkOutput("reset.itc", itc, 8'd0);

    // Release reset and start a charge in TC
    applyStimulus(1);
    rst      = 1'b0;
    en       = 1'b1;
    vtok     = 1'b1;
    vbat     = 8'd150;
    vcutoff  = 8'd153;
    itc_cfg  = 8'd25;
    icc_cfg  = 8'd200;
    vcv_cfg  = 8'd188;
    iend_cfg = 8'd13;
    vpreset  = 8'd170;
    ibat     = 8'd200;
    tmax     = 8'd0;
    applyStimulus(1);
    checkModes("startTc", 3'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("startTc.itc", itc, 8'd25);
    checkOutput("startTc.icc", icc, 8'd200);
    checkOutput("startTc.vcv", vcv, 8'd188);

    // TC->CC with a one-cycle glitch that restarts the debounce
    vbat = 8'd160;
    applyStimulus(3);
    checkOutput("tcGlitch.pre", {5'd0, state}, 8'd1);
    vbat = 8'd150;
    applyStimulus(1);
    checkOutput("tcGlitch.drop", {5'd0, state}, 8'd1);
    vbat = 8'd160;
    applyStimulus(3);
    checkOutput("tcGlitch.three", {5'd0, state}, 8'd1);
    applyStimulus(1);
    checkModes("tcToCc", 3'd2, 1'b0, 1'b1, 1'b0);

    // CC compares against the latched vcv, not the live config
    vcv_cfg = 8'd100;
    applyStimulus(5);
    checkOutput("ccLatched.state", {5'd0, state}, 8'd2);
    checkOutput("ccLatched.vcv", vcv, 8'd188);

    // CC->CV at exactly the target (>= boundary)
    vbat = 8'd188;
    applyStimulus(3);
    checkOutput("ccToCv.three", {5'd0, state}, 8'd2);
    applyStimulus(1);
    checkModes("ccToCv", 3'd3, 1'b0, 1'b0, 1'b1);

    // CV->END on low current
    ibat = 8'd10;
    applyStimulus(3);
    checkOutput("cvToEnd.three", {5'd0, state}, 8'd3);
    applyStimulus(1);
    checkModes("cvToEnd", 3'd4, 1'b0, 1'b0, 1'b0);

    // Recharge: vbat equal to vpreset is not below it
    vbat = 8'd170;
    applyStimulus(5);
    checkOutput("endHold", {5'd0, state}, 8'd4);
    vbat = 8'd169;
    applyStimulus(3);
    checkOutput("recharge.three", {5'd0, state}, 8'd4);
    applyStimulus(1);
    checkModes("recharge", 3'd2, 1'b0, 1'b1, 1'b0);
    checkOutput("recharge.vcv", vcv, 8'd188);

    // vtok low aborts to IDLE on the next edge
    vcv_cfg = 8'd180;
    icc_cfg = 8'd99;
    vtok    = 1'b0;
    applyStimulus(1);
    checkModes("abort", 3'd0, 1'b0, 1'b0, 1'b0);

    // Leaving IDLE again relatches the new targets
    vtok = 1'b1;
    applyStimulus(1);
    checkModes("relatch", 3'd2, 1'b0, 1'b1, 1'b0);
    checkOutput("relatch.vcv", vcv, 8'd180);
    checkOutput("relatch.icc", icc, 8'd99);

    // Timeout: tmax=2 ticks of 16 cycles -> END after 32 cycles in CV
    en = 1'b0;
    applyStimulus(1);
    checkOutput("toIdle", {5'd0, state}, 8'd0);
    vbat    = 8'd200;
    vcv_cfg = 8'd188;
    ibat    = 8'd200;
    tmax    = 8'd2;
    en      = 1'b1;
    applyStimulus(1);
    checkModes("idleToCv", 3'd3, 1'b0, 1'b0, 1'b1);
    applyStimulus(31);
    checkOutput("timeout.31", {5'd0, state}, 8'd3);
    applyStimulus(1);
    checkModes("timeout.32", 3'd4, 1'b0, 1'b0, 1'b0);

    // tmax=0 disables the timeout
    en = 1'b0;
    applyStimulus(1);
    tmax = 8'd0;
    en   = 1'b1;
    applyStimulus(1);
    checkOutput("noTimeout.entry", {5'd0, state}, 8'd3);
    applyStimulus(60);
    checkModes("noTimeout", 3'd3, 1'b0, 1'b0, 1'b1);

    // Reset pulse mid-CV clears everything before the next edge
    rst = 1'b1;
    #2;
    checkModes("midReset", 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("midReset.vcv", vcv, 8'd0);
    checkOutput("midReset.itc", itc, 8'd0);
    rst = 1'b0;
    applyStimulus(1);
    checkModes("afterReset", 3'd3, 1'b0, 1'b0, 1'b1);
    checkOutput("afterReset.vcv", vcv, 8'd188);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
